// File: rtl/unconfig_int_sub.sv
// Two-stage pipelined approximate subtractor c = a - b on the upper OP_BITWIDTH bits.
// Define APX_SUB_BORROW_SAT_EN to clamp the result to zero when a borrow occurs.
module unconfig_int_sub #(
  parameter int unsigned OP_BITWIDTH        = 32,
  parameter int unsigned DATA_PATH_BITWIDTH = 32,
  parameter int unsigned CNT_BITWIDTH       = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0] a,
  input  logic [DATA_PATH_BITWIDTH-1:0] b,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_PATH_BITWIDTH-1:0] c,
  output logic                          borrow,
  output logic [CNT_BITWIDTH-1:0]       done_cnt
);

  localparam int unsigned DW = DATA_PATH_BITWIDTH;
  localparam int unsigned OW = OP_BITWIDTH;

  logic [DW-1:0]           a_q, a_d, b_q, b_d;
  logic                    s1_valid_q, s1_valid_d;
  logic [DW-1:0]           c_q, c_d;
  logic                    borrow_q, borrow_d;
  logic                    out_valid_q, out_valid_d;
  logic [CNT_BITWIDTH-1:0] cnt_q, cnt_d;

  logic          s2_load;
  logic          in_fire;
  logic          out_fire;
  logic [OW-1:0] at, bt;
  logic [OW:0]   diff;
  logic [DW-1:0] diff_aligned;

  assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
  assign in_ready = ~s1_valid_q | s2_load;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

  assign at   = a_q[DW-1 -: OW];
  assign bt   = b_q[DW-1 -: OW];
  assign diff = {1'b0, at} - {1'b0, bt};

  // Shift keeps the OW == DW case free of zero-width slices.
  always_comb begin
    diff_aligned = DW'(diff[OW-1:0]) << (DW - OW);
`ifdef APX_SUB_BORROW_SAT_EN
    if (diff[OW]) begin
      diff_aligned = '0;
    end
`endif
  end

  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    s1_valid_d = s1_valid_q;
    if (in_fire) begin
      a_d        = a;
      b_d        = b;
      s1_valid_d = 1'b1;
    end else if (s2_load) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    c_d         = c_q;
    borrow_d    = borrow_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    if (s2_load) begin
      c_d         = diff_aligned;
      borrow_d    = diff[OW];
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
    if (out_fire) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q         <= '0;
      b_q         <= '0;
      s1_valid_q  <= 1'b0;
      c_q         <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      a_q         <= a_d;
      b_q         <= b_d;
      s1_valid_q  <= s1_valid_d;
      c_q         <= c_d;
      borrow_q    <= borrow_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign borrow    = borrow_q;
  assign done_cnt  = cnt_q;

endmodule

// File: tb/tb_unconfig_int_sub.sv
// Directed self-checking bench for unconfig_int_sub (full-width and OW=16 instances).
module tb_unconfig_int_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, borrow;
  logic [31:0] a, b, c;
  logic [15:0] done_cnt;

  logic        in_valid_t, in_ready_t, out_valid_t, out_ready_t, borrow_t;
  logic [31:0] a_t, b_t, c_t;
  logic [15:0] done_cnt_t;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unconfig_int_sub #(.OP_BITWIDTH(32), .DATA_PATH_BITWIDTH(32), .CNT_BITWIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .c(c), .borrow(borrow), .done_cnt(done_cnt)
  );

  unconfig_int_sub #(.OP_BITWIDTH(16), .DATA_PATH_BITWIDTH(32), .CNT_BITWIDTH(16)) dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid_t), .in_ready(in_ready_t), .a(a_t), .b(b_t),
    .out_valid(out_valid_t), .out_ready(out_ready_t), .c(c_t), .borrow(borrow_t),
    .done_cnt(done_cnt_t)
  );

  // Reference for the full-width instance: {borrow, c}.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y);
    logic [32:0] d;
    d = {1'b0, x} - {1'b0, y};
`ifdef APX_SUB_BORROW_SAT_EN
    if (d[32]) d[31:0] = '0;
`endif
    return d;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid_t = 1'b0; out_ready_t = 1'b0; a_t = '0; b_t = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++; if (c !== 32'h0) begin errors++; $display("FAIL reset_c got %h exp 0", c); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got %b exp 0", borrow); end
    checks++; if (done_cnt !== 16'd0) begin errors++; $display("FAIL reset_done_cnt got %0d exp 0", done_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  // Single transaction on the full-width instance with out_ready held high.
  task automatic single_op(input string name, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] exp_c, input logic exp_b, input logic [15:0] exp_cnt);
    in_valid = 1'b1; a = x; b = y; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_latency got out_valid=%b exp 0", name, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL %s_valid got %b exp 1", name, out_valid); end
    checks++; if (c !== exp_c) begin errors++; $display("FAIL %s_c got %h exp %h", name, c, exp_c); end
    checks++; if (borrow !== exp_b) begin errors++; $display("FAIL %s_borrow got %b exp %b", name, borrow, exp_b); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL %s_drain got out_valid=%b exp 0", name, out_valid); end
    checks++; if (done_cnt !== exp_cnt) begin errors++; $display("FAIL %s_done_cnt got %0d exp %0d", name, done_cnt, exp_cnt); end
  endtask

  task automatic test_basic();
    single_op("basic", 32'd100, 32'd58, 32'd42, 1'b0, 16'd1);
  endtask

  task automatic test_borrow();
`ifdef APX_SUB_BORROW_SAT_EN
    single_op("borrow", 32'd5, 32'd7, 32'h0000_0000, 1'b1, 16'd2);
`else
    single_op("borrow", 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b1, 16'd2);
`endif
  endtask

  task automatic test_truncation();
    in_valid_t = 1'b1; a_t = 32'h0005_FFFF; b_t = 32'h0003_0001; out_ready_t = 1'b1;
    @(negedge clk);
    in_valid_t = 1'b0;
    @(negedge clk);
    checks++; if (out_valid_t !== 1'b1) begin errors++; $display("FAIL trunc_valid got %b exp 1", out_valid_t); end
    checks++; if (c_t !== 32'h0002_0000) begin errors++; $display("FAIL trunc_c got %h exp 00020000", c_t); end
    checks++; if (borrow_t !== 1'b0) begin errors++; $display("FAIL trunc_borrow got %b exp 0", borrow_t); end
    // Lower-half borrow must not leak into the upper field.
    in_valid_t = 1'b1; a_t = 32'h0003_0000; b_t = 32'h0003_FFFF;
    @(negedge clk);
    in_valid_t = 1'b0;
    @(negedge clk);
    checks++; if (c_t !== 32'h0000_0000 || borrow_t !== 1'b0) begin
      errors++; $display("FAIL trunc_low_ignored got c=%h borrow=%b exp c=0 borrow=0", c_t, borrow_t);
    end
    @(negedge clk);
    out_ready_t = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] pa [4] = '{32'd10, 32'd0, 32'd1000, 32'h8000_0000};
    logic [31:0] pb [4] = '{32'd3, 32'd1, 32'd1, 32'h0000_0001};
    int          idx = 0;
    int          got = 0;
    int          stall_left = 0;
    bit          seen = 1'b0;
    logic [31:0] held_c = '0;
    logic [32:0] e;
    do_reset();
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      if (out_valid && !seen) begin
        seen = 1'b1; stall_left = 3; held_c = c;
      end
      if (stall_left > 0) begin
        stall_left--;
        out_ready = 1'b0;
        checks++; if (c !== held_c || out_valid !== 1'b1) begin
          errors++; $display("FAIL stall_hold got c=%h v=%b exp c=%h v=1", c, out_valid, held_c);
        end
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %b exp 0", in_ready); end
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          e = model(pa[got], pb[got]);
          checks++; if ({borrow, c} !== e) begin
            errors++; $display("FAIL bp_result%0d got b=%b c=%h exp b=%b c=%h", got, borrow, c, e[32], e[31:0]);
          end
          got++;
        end
        #1;
      end
      if (idx < 4) begin
        in_valid = 1'b1; a = pa[idx]; b = pb[idx];
        if (in_ready) idx++;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_count got %0d exp 4", got); end
    @(negedge clk);
    checks++; if (done_cnt !== 16'd4 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_done_cnt got cnt=%0d v=%b exp cnt=4 v=0", done_cnt, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; a = 32'd9; b = 32'd4;
    @(negedge clk);
    a = 32'd8; b = 32'd2;
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL mid_setup got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
    end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || c !== 32'h0 || borrow !== 1'b0 || done_cnt !== 16'd0) begin
      errors++; $display("FAIL mid_reset got v=%b c=%h b=%b cnt=%0d exp all 0", out_valid, c, borrow, done_cnt);
    end
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready got %b exp 1", in_ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got out_valid=%b exp 0", i, out_valid); end
    end
  endtask

  initial begin
    rst = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_truncation();
    test_backpressure();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
